// File: rtl/bit_clmul_radix_pkg.sv
// Shared types for the iterative carry-less multiplier.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package bit_clmul_radix_pkg;

    // Controller states: idle, iterating, result-valid.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } bit_clmul_radix_state_type;

    // One-hot operation select, bit order matches the op port {clmulr, clmulh, clmul}.
    typedef struct packed {
        logic bit_clmulr;
        logic bit_clmulh;
        logic bit_clmul;
    } bit_op_type;

    // Reduce a possibly multi-hot op to a single operation: clmul > clmulh > clmulr.
    function automatic bit_op_type op_priority(input logic [2:0] op);
        bit_op_type o;
        o = '0;
        if (op[0]) begin
            o.bit_clmul = 1'b1;
        end else if (op[1]) begin
            o.bit_clmulh = 1'b1;
        end else if (op[2]) begin
            o.bit_clmulr = 1'b1;
        end
        return o;
    endfunction

endpackage

// File: rtl/bit_clmul_radix_clmul_step.sv
// One radix step: XOR of a shifted by (cnt*STEP + j) for every set bit j of the STEP-bit slice of b.
// Latency: purely combinational.
// Backpressure: none.
module clmul_step
    import bit_clmul_radix_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1,
    parameter int CW   = 5
) (
    input  logic [XLEN-1:0]   a,
    input  logic [STEP-1:0]   b_bits,
    input  logic [CW-1:0]     cnt,
    output logic [2*XLEN-1:0] part
);

    logic [2*XLEN-1:0] a_ext;

    assign a_ext = {{XLEN{1'b0}}, a};

    // Partial product for this step, placed at the bit position the counter has reached.
    always_comb begin
        part = '0;
        for (int j = 0; j < STEP; j++) begin
            if (b_bits[j]) begin
                part = part ^ (a_ext << (int'(cnt) * STEP + j));
            end
        end
    end

endmodule

// File: rtl/bit_clmul_radix.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr), STEP multiplier bits per cycle.
// Latency: accept + k CALC cycles, ready pulse in cycle k+1 (k <= XLEN/STEP, early-out on zero b).
// Backpressure: none; enable is only sampled in IDLE/DONE, kill aborts to IDLE without ready.
module bit_clmul_radix
    import bit_clmul_radix_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int STEP      = 1,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic            kill,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    localparam int NSTEPS = XLEN / STEP;
    // A single-step configuration still needs a one-bit counter to stay legal.
    localparam int CW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSTEPS - 1);

    typedef struct packed {
        logic            enable;
        logic [2:0]      op;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic            kill;
    } bit_clmul_radix_in_type;

    typedef struct packed {
        logic            busy;
        logic            ready;
        logic [XLEN-1:0] result;
    } bit_clmul_radix_out_type;

    typedef struct packed {
        bit_clmul_radix_state_type state;
        bit_op_type                op;
        logic [XLEN-1:0]           a;
        logic [XLEN-1:0]           b;
        logic [2*XLEN-1:0]         acc;
        logic [CW-1:0]             cnt;
        logic [XLEN-1:0]           result;
    } bit_clmul_radix_reg_type;

    localparam bit_clmul_radix_reg_type init_bit_clmul_radix_reg = '0;

    bit_clmul_radix_in_type  d;
    bit_clmul_radix_out_type q;
    bit_clmul_radix_reg_type r;
    bit_clmul_radix_reg_type rin;

    logic [2*XLEN-1:0] part;
    logic [2*XLEN-1:0] acc_nx;
    logic [XLEN-1:0]   b_nx;

    // Select the product slice for the latched operation.
    function automatic logic [XLEN-1:0] pick(input bit_op_type o, input logic [2*XLEN-1:0] acc);
        if (o.bit_clmul) begin
            return acc[XLEN-1:0];
        end else if (o.bit_clmulh) begin
            return acc[2*XLEN-1:XLEN];
        end
        return acc[2*XLEN-2:XLEN-1];
    endfunction

    assign d = '{enable: enable, op: op, rdata1: rdata1, rdata2: rdata2, kill: kill};

    clmul_step #(
        .XLEN (XLEN),
        .STEP (STEP),
        .CW   (CW)
    ) u_step (
        .a      (r.a),
        .b_bits (r.b[STEP-1:0]),
        .cnt    (r.cnt),
        .part   (part)
    );

    assign acc_nx = r.acc ^ part;
    assign b_nx   = r.b >> STEP;

    // Next-state: accept in IDLE/DONE, iterate in CALC, kill forces IDLE and freezes result.
    always_comb begin
        rin = r;
        unique case (r.state)
            ST_IDLE, ST_DONE: begin
                rin.state = ST_IDLE;
                if (d.enable && (d.op != 3'b000)) begin
                    rin.op  = op_priority(d.op);
                    rin.a   = d.rdata1;
                    rin.b   = d.rdata2;
                    rin.acc = '0;
                    rin.cnt = '0;
                    if ((EARLY_OUT != 0) && (d.rdata2 == '0)) begin
                        // Cleared accumulator: every slice of the product is zero.
                        rin.state  = ST_DONE;
                        rin.result = '0;
                    end else begin
                        rin.state = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rin.acc = acc_nx;
                rin.b   = b_nx;
                rin.cnt = r.cnt + CW'(1);
                if ((r.cnt == CNT_LAST) || ((EARLY_OUT != 0) && (b_nx == '0))) begin
                    rin.state  = ST_DONE;
                    rin.result = pick(r.op, acc_nx);
                end
            end
            default: begin
                rin.state = ST_IDLE;
            end
        endcase
        if (d.kill) begin
            rin.state  = ST_IDLE;
            rin.result = r.result;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= init_bit_clmul_radix_reg;
        end else begin
            r <= rin;
        end
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        q.busy   = (r.state == ST_CALC);
        q.ready  = (r.state == ST_DONE);
        q.result = r.result;
    end

    assign busy   = q.busy;
    assign ready  = q.ready;
    assign result = q.result;

endmodule

// File: tb/tb_bit_clmul_radix.sv
module tb_bit_clmul_radix;

    localparam int NRAND = 400;
    localparam int NCFG  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rand_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mask64(input int x);
        if (x >= 64) return '1;
        return (64'd1 << x) - 64'd1;
    endfunction

    // Carry-less product from the definition, then slice by the highest-priority op bit.
    function automatic logic [63:0] ref_clmul(input int x, input logic [2:0] o,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < x; i++) begin
            if (b[i]) p = p ^ ({64'd0, a} << i);
        end
        if (o[0]) return p[63:0] & mask64(x);
        if (o[1]) return 64'(p >> x) & mask64(x);
        return 64'(p >> (x - 1)) & mask64(x);
    endfunction

    // Cycles from accept to ready.
    function automatic int lat_model(input int x, input int s, input int e, input logic [63:0] b);
        int top;
        top = -1;
        for (int i = 0; i < x; i++) begin
            if (b[i]) top = i;
        end
        if (e == 0) return x / s + 1;
        if (top < 0) return 1;
        return (top + s) / s + 1;
    endfunction

    // ---------------- directed DUTs: STEP=1 and STEP=8 share inputs ----------------
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rdata1 = '0;
    logic [31:0] rdata2 = '0;
    logic        kill = 1'b0;
    logic        busy, ready, busy8, ready8;
    logic [31:0] result, result8;

    bit_clmul_radix #(.XLEN(32), .STEP(1), .EARLY_OUT(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .op(op), .rdata1(rdata1), .rdata2(rdata2),
        .kill(kill), .busy(busy), .ready(ready), .result(result)
    );

    bit_clmul_radix #(.XLEN(32), .STEP(8), .EARLY_OUT(1)) dut8 (
        .clk(clk), .rst(rst), .enable(enable), .op(op), .rdata1(rdata1), .rdata2(rdata2),
        .kill(kill), .busy(busy8), .ready(ready8), .result(result8)
    );

    // ---------------- directed DUT without early-out ----------------
    logic        rst_ne = 1'b1;
    logic        en_ne = 1'b0;
    logic [2:0]  op_ne = 3'b000;
    logic [31:0] a_ne = '0;
    logic [31:0] b_ne = '0;
    logic        kill_ne = 1'b0;
    logic        busy_ne, ready_ne;
    logic [31:0] res_ne;

    bit_clmul_radix #(.XLEN(32), .STEP(1), .EARLY_OUT(0)) dut_ne (
        .clk(clk), .rst(rst_ne), .enable(en_ne), .op(op_ne), .rdata1(a_ne), .rdata2(b_ne),
        .kill(kill_ne), .busy(busy_ne), .ready(ready_ne), .result(res_ne)
    );

    // Called #1 after a rising edge; returns latency (0 = never) and result of both DUTs.
    task automatic run_pair(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int lat1, output int lat8,
                            output logic [31:0] r1, output logic [31:0] r8);
        lat1 = 0; lat8 = 0; r1 = '0; r8 = '0;
        enable = 1'b1; op = o; rdata1 = a; rdata2 = b;
        @(posedge clk); #1;
        enable = 1'b0; op = 3'($urandom); rdata1 = $urandom; rdata2 = $urandom;
        for (int c = 1; c <= 40; c++) begin
            if (ready && lat1 == 0) begin lat1 = c; r1 = result; end
            if (ready8 && lat8 == 0) begin lat8 = c; r8 = result8; end
            if (lat1 != 0 && lat8 != 0) break;
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int l1, l8, c, nrdy;
        logic [31:0] r1, r8;

        tbl[0] = '{3'b001, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005, 3};
        tbl[1] = '{3'b010, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        tbl[2] = '{3'b100, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 33};
        tbl[3] = '{3'b001, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1};
        tbl[4] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 2};
        tbl[5] = '{3'b111, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005, 3};
        tbl[6] = '{3'b110, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        tbl[7] = '{3'b010, 32'h8000_0001, 32'h0000_0003, 32'h0000_0001, 3};

        // Reset must win over a simultaneous enable.
        enable = 1'b1; op = 3'b001; rdata1 = 32'd3; rdata2 = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_result8", 64'(result8), 64'd0);
        rst = 1'b0; rst_ne = 1'b0; enable = 1'b0;
        @(posedge clk); #1;

        // Table: STEP=1 result/latency, STEP=8 identical result with its own latency.
        for (int i = 0; i < 8; i++) begin
            run_pair(tbl[i].op, tbl[i].a, tbl[i].b, l1, l8, r1, r8);
            chk($sformatf("vec%0d_res", i), 64'(r1), 64'(tbl[i].res));
            chk($sformatf("vec%0d_lat", i), 64'(l1), 64'(tbl[i].lat));
            chk($sformatf("vec%0d_res8", i), 64'(r8), 64'(tbl[i].res));
            chk($sformatf("vec%0d_lat8", i), 64'(l8), 64'(lat_model(32, 8, 1, {32'd0, tbl[i].b})));
            @(posedge clk); #1;
        end

        // enable with no op bit is ignored.
        enable = 1'b1; op = 3'b000; rdata1 = 32'd7; rdata2 = 32'd7;
        @(posedge clk); #1;
        chk("op0_busy", 64'(busy), 64'd0);
        chk("op0_ready", 64'(ready), 64'd0);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("op0_ready2", 64'(ready), 64'd0);

        // Back-to-back: second accept in the DONE cycle goes straight to CALC.
        enable = 1'b1; op = 3'b001; rdata1 = 32'd3; rdata2 = 32'd3;
        @(posedge clk); #1;
        enable = 1'b0;
        c = 0;
        while (!ready && c < 40) begin @(posedge clk); #1; c++; end
        chk("b2b_first_ready", 64'(ready), 64'd1);
        chk("b2b_first_res", 64'(result), 64'h5);
        enable = 1'b1; op = 3'b001; rdata1 = 32'hFFFF_FFFF; rdata2 = 32'h1;
        @(posedge clk); #1;
        enable = 1'b0;
        chk("b2b_no_bubble_busy", 64'(busy), 64'd1);
        chk("b2b_no_ready", 64'(ready), 64'd0);
        @(posedge clk); #1;
        chk("b2b_ready", 64'(ready), 64'd1);
        chk("b2b_res", 64'(result), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("b2b_ready_pulse", 64'(ready), 64'd0);
        chk("b2b_res_hold", 64'(result), 64'hFFFF_FFFF);

        // Full-length latency without early-out.
        en_ne = 1'b1; op_ne = 3'b001; a_ne = 32'd3; b_ne = 32'd3;
        @(posedge clk); #1;
        en_ne = 1'b0;
        c = 1;
        while (!ready_ne && c < 40) begin @(posedge clk); #1; c++; end
        chk("ne_lat", 64'(c), 64'd33);
        chk("ne_res", 64'(res_ne), 64'h5);
        @(posedge clk); #1;

        // Kill during cycle 5 of a 33-cycle operation.
        en_ne = 1'b1; op_ne = 3'b010; a_ne = 32'hFFFF_FFFF; b_ne = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        en_ne = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("kill_busy_before", 64'(busy_ne), 64'd1);
        kill_ne = 1'b1;
        @(posedge clk); #1;
        kill_ne = 1'b0;
        chk("kill_busy", 64'(busy_ne), 64'd0);
        chk("kill_ready", 64'(ready_ne), 64'd0);
        chk("kill_res_hold", 64'(res_ne), 64'h5);
        nrdy = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_ne || busy_ne) nrdy++;
        end
        chk("kill_no_late_ready", 64'(nrdy), 64'd0);

        // Kill beats a simultaneous enable.
        en_ne = 1'b1; kill_ne = 1'b1; op_ne = 3'b001; a_ne = 32'd3; b_ne = 32'd3;
        @(posedge clk); #1;
        en_ne = 1'b0; kill_ne = 1'b0;
        chk("kill_en_busy", 64'(busy_ne), 64'd0);
        chk("kill_en_ready", 64'(ready_ne), 64'd0);

        // Reset in the middle of CALC clears every output.
        en_ne = 1'b1; op_ne = 3'b001; a_ne = 32'd3; b_ne = 32'd3;
        @(posedge clk); #1;
        en_ne = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_ne = 1'b1;
        @(posedge clk); #1;
        rst_ne = 1'b0;
        chk("midrst_busy", 64'(busy_ne), 64'd0);
        chk("midrst_ready", 64'(ready_ne), 64'd0);
        chk("midrst_result", 64'(res_ne), 64'd0);

        c = 0;
        while (rand_done < NCFG && c < 40000) begin @(posedge clk); c++; end
        chk("random_blocks_done", 64'(rand_done), 64'(NCFG));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- random regression over several configurations ----------------
    for (genvar g = 0; g < NCFG; g++) begin : g_rand
        localparam int X = (g < 3) ? 32 : 64;
        localparam int S = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 8);
        localparam int E = (g % 2 == 0) ? 1 : 0;

        logic          en_r = 1'b0;
        logic [2:0]    op_r = 3'b000;
        logic [X-1:0]  a_r = '0;
        logic [X-1:0]  b_r = '0;
        logic          kill_r = 1'b0;
        logic          busy_r, rdy_r;
        logic [X-1:0]  res_r;

        bit_clmul_radix #(.XLEN(X), .STEP(S), .EARLY_OUT(E)) u_dut (
            .clk(clk), .rst(rst), .enable(en_r), .op(op_r), .rdata1(a_r), .rdata2(b_r),
            .kill(kill_r), .busy(busy_r), .ready(rdy_r), .result(res_r)
        );

        initial begin
            logic [63:0] a64, b64, expv;
            logic [2:0]  o;
            int          msb, lat, explat;
            repeat (3) @(posedge clk);
            while (rst) @(posedge clk);
            #1;
            for (int n = 0; n < NRAND; n++) begin
                a64 = {$urandom, $urandom} & mask64(X);
                b64 = {$urandom, $urandom};
                msb = $urandom_range(X, 0);
                if (msb == 0) b64 = '0;
                else b64 = (b64 & mask64(msb)) | (64'd1 << (msb - 1));
                o = 3'($urandom_range(7, 1));
                expv   = ref_clmul(X, o, a64, b64);
                explat = lat_model(X, S, E, b64);
                en_r = 1'b1; op_r = o; a_r = a64[X-1:0]; b_r = b64[X-1:0];
                @(posedge clk); #1;
                en_r = 1'b0;
                op_r = 3'($urandom); a_r = a64[X-1:0] ^ X'($urandom); b_r = ~b64[X-1:0];
                lat = 1;
                while (!rdy_r && lat <= X + 4) begin @(posedge clk); #1; lat++; end
                chk($sformatf("rand_x%0d_s%0d_e%0d_n%0d_lat", X, S, E, n), 64'(lat), 64'(explat));
                chk($sformatf("rand_x%0d_s%0d_e%0d_n%0d_res", X, S, E, n), 64'(res_r), expv);
                @(posedge clk); #1;
            end
            rand_done++;
        end
    end

endmodule
